// File: rtl/multi_divider.sv
// CHANNELS independent sysclk dividers (toggle or pulse mode); Scale/Mode latch only at terminal count.
// Outputs registered, one cycle after cnt reaches sc; no backpressure. Optional Sync port via DIVIDER_SYNC_EN.
module multi_divider #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 6
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       Enable,
    input  logic [CHANNELS*WIDTH-1:0] Scale,
    input  logic [CHANNELS-1:0]       Mode,
`ifdef DIVIDER_SYNC_EN
    input  logic                      Sync,
`endif
    output logic [CHANNELS-1:0]       Slow_clk,
    output logic [CHANNELS-1:0]       Tick
);

    logic sync_hit;
`ifdef DIVIDER_SYNC_EN
    assign sync_hit = Sync;
`else
    assign sync_hit = 1'b0;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] sc;
        logic [WIDTH-1:0] scale_in;
        logic             md;
        logic             slow;
        logic             tick;
        logic             tc;

        assign scale_in = Scale[i*WIDTH +: WIDTH];
        assign tc       = Enable[i] && (cnt == sc);

        // md used for the output decision is the one latched for the period now ending.
        always_ff @(posedge sysclk) begin
            if (reset) begin
                cnt  <= '0;
                sc   <= '0;
                md   <= 1'b0;
                slow <= 1'b0;
                tick <= 1'b0;
            end else if (!Enable[i] || sync_hit) begin
                cnt  <= '0;
                sc   <= scale_in;
                md   <= Mode[i];
                slow <= 1'b0;
                tick <= 1'b0;
            end else if (tc) begin
                cnt  <= '0;
                sc   <= scale_in;
                md   <= Mode[i];
                tick <= 1'b1;
                slow <= md ? 1'b1 : ~slow;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
                if (md) slow <= 1'b0;
            end
        end

        assign Slow_clk[i] = slow;
        assign Tick[i]     = tick;
    end

endmodule
